// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, DMA and memory-side signals around the data-port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_hold;

  logic              dma_req;
  logic              dma_we;
  logic [3:0]        dma_wen;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_din;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_dout;

  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_wen, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_wen, dma_addr, dma_din,
    input  mem_dout,
    output cpu_dout, cpu_hold,
    output dma_gnt, dma_rvalid, dma_dout,
    output mem_en, mem_wen, mem_addr, mem_din,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_wen, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_wen, dma_addr, dma_din,
    output mem_dout,
    input  cpu_dout, cpu_hold,
    input  dma_gnt, dma_rvalid, dma_dout,
    input  mem_en, mem_wen, mem_addr, mem_din,
    input  busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-port arbiter: shares one memory port between the CPU load/store path and a DMA master.
// Define DMEM_ARB_FAIRNESS_EN to add the DMA starvation guard; otherwise the CPU has strict priority.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DMA_WAIT_MAX = 8
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);

  if (DMA_WAIT_MAX < 1 || DMA_WAIT_MAX > 255) begin : g_wait_range
    $error("DMA_WAIT_MAX must lie in 1..255");
  end

  logic              cpu_gnt;
  logic              dma_gnt_c;
  logic              force_dma;
  logic              rd_grant;
  logic              rd_pend;
  logic              rd_owner;
  logic              cpu_ret;
  logic              dma_ret;
  logic [DATA_W-1:0] cpu_dout_q;
  logic [DATA_W-1:0] dma_dout_q;

`ifdef DMEM_ARB_FAIRNESS_EN
  logic [7:0] wait_cnt;

  assign force_dma = bus.dma_req && (wait_cnt == 8'(DMA_WAIT_MAX));

  // Counts consecutive refused DMA cycles; saturates at the limit, which forces the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!bus.dma_req || dma_gnt_c) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'(DMA_WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_c = 1'b0;
    if (force_dma) begin
      dma_gnt_c = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (bus.dma_req) begin
      dma_gnt_c = 1'b1;
    end
  end

  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_wen  = 4'b0000;
    bus.mem_addr = {ADDR_W{1'b0}};
    bus.mem_din  = {DATA_W{1'b0}};
    if (cpu_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_wen  = bus.cpu_we ? bus.cpu_wen : 4'b0000;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_din;
    end else if (dma_gnt_c) begin
      bus.mem_en   = 1'b1;
      bus.mem_wen  = bus.dma_we ? bus.dma_wen : 4'b0000;
      bus.mem_addr = bus.dma_addr;
      bus.mem_din  = bus.dma_din;
    end
  end

  assign bus.cpu_hold = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt  = dma_gnt_c;
  assign rd_grant     = (cpu_gnt & ~bus.cpu_we) | (dma_gnt_c & ~bus.dma_we);

  // Grant stage -> return stage: remember who owns the read data arriving next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= rd_grant;
      rd_owner <= dma_gnt_c;
    end
  end

  assign cpu_ret = rd_pend & ~rd_owner;
  assign dma_ret = rd_pend & rd_owner;

  // Return stage: capture the returned word so each owner sees it held until its next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_dout_q <= {DATA_W{1'b0}};
      dma_dout_q <= {DATA_W{1'b0}};
    end else begin
      if (cpu_ret) cpu_dout_q <= bus.mem_dout;
      if (dma_ret) dma_dout_q <= bus.mem_dout;
    end
  end

  assign bus.cpu_dout   = cpu_ret ? bus.mem_dout : cpu_dout_q;
  assign bus.dma_dout   = dma_ret ? bus.mem_dout : dma_dout_q;
  assign bus.dma_rvalid = dma_ret;
  assign bus.busy       = rd_pend | bus.cpu_req | bus.dma_req;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_dmem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WMAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_WAIT_MAX(WMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: 1-cycle read latency, byte-enabled writes, garbage on the data bus otherwise.
  logic [31:0] mem [logic [29:0]];
  logic [31:0] wr_word;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wen != 4'h0) begin
      wr_word = mem_rd(bus.mem_addr);
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b]) wr_word[8*b +: 8] = bus.mem_din[8*b +: 8];
      mem[bus.mem_addr[31:2]] = wr_word;
      bus.mem_dout <= $urandom;
    end else if (bus.mem_en) begin
      bus.mem_dout <= mem_rd(bus.mem_addr);
    end else begin
      bus.mem_dout <= $urandom;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wen = 4'h0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_wen = 4'h0; bus.dma_addr = '0; bus.dma_din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", bus.mem_en); end
    total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL reset_cpu_hold got=%b exp=0", bus.cpu_hold); end
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset_dma_rvalid got=%b exp=0", bus.dma_rvalid); end
    total++; if (bus.cpu_dout !== 32'h0) begin bad++; $display("FAIL reset_cpu_dout got=%h exp=0", bus.cpu_dout); end
    total++; if (bus.dma_dout !== 32'h0) begin bad++; $display("FAIL reset_dma_dout got=%h exp=0", bus.dma_dout); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read();
    mem[30'(32'h0001_0010 >> 2)] = 32'hDEAD_BEEF;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_wen = 4'hF; bus.cpu_addr = 32'h0001_0010;
    @(negedge clk);
    total++; if (bus.mem_en !== 1'b1) begin bad++; $display("FAIL rd_mem_en got=%b exp=1", bus.mem_en); end
    total++; if (bus.mem_wen !== 4'h0) begin bad++; $display("FAIL rd_mem_wen got=%h exp=0", bus.mem_wen); end
    total++; if (bus.mem_addr !== 32'h0001_0010) begin bad++; $display("FAIL rd_mem_addr got=%h exp=00010010", bus.mem_addr); end
    total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL rd_hold got=%b exp=0", bus.cpu_hold); end
    @(posedge clk); #1;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.cpu_dout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_cpu_dout[%0d] got=%h exp=deadbeef", k, bus.cpu_dout); end
      total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL rd_hold_after[%0d] got=%b exp=0", k, bus.cpu_hold); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_rd;
    exp_rd = mem_rd(32'h0000_0100);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0100;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_wen = 4'hF; bus.dma_addr = 32'h0000_0040; bus.dma_din = 32'h1234_5678;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL col_c0_dma_gnt got=%b exp=0", bus.dma_gnt); end
    total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL col_c0_hold got=%b exp=0", bus.cpu_hold); end
    total++; if (bus.mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL col_c0_addr got=%h exp=00000100", bus.mem_addr); end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL col_c1_dma_gnt got=%b exp=1", bus.dma_gnt); end
    total++; if (bus.mem_wen !== 4'hF) begin bad++; $display("FAIL col_c1_wen got=%h exp=f", bus.mem_wen); end
    total++; if (bus.mem_din !== 32'h1234_5678) begin bad++; $display("FAIL col_c1_din got=%h exp=12345678", bus.mem_din); end
    total++; if (bus.mem_addr !== 32'h0000_0040) begin bad++; $display("FAIL col_c1_addr got=%h exp=00000040", bus.mem_addr); end
    total++; if (bus.cpu_dout !== exp_rd) begin bad++; $display("FAIL col_c1_cpu_dout got=%h exp=%h", bus.cpu_dout, exp_rd); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL col_write_rvalid got=%b exp=0", bus.dma_rvalid); end
    total++; if (mem_rd(32'h0000_0040) !== 32'h1234_5678) begin bad++; $display("FAIL col_mem_written got=%h exp=12345678", mem_rd(32'h0000_0040)); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    bit exp_d;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0200;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_wen = 4'h3; bus.dma_addr = 32'h0000_0300; bus.dma_din = 32'hCAFE_0001;
`ifdef DMEM_ARB_FAIRNESS_EN
    // DMA is refused WMAX times, then takes one cycle; the pattern repeats with period WMAX+1.
    for (int k = 0; k < 3 * (WMAX + 1); k++) begin
      exp_d = ((k % (WMAX + 1)) == WMAX);
      @(negedge clk);
      total++; if (bus.dma_gnt !== exp_d) begin bad++; $display("FAIL starve_dma_gnt[%0d] got=%b exp=%b", k, bus.dma_gnt, exp_d); end
      total++; if (bus.cpu_hold !== exp_d) begin bad++; $display("FAIL starve_hold[%0d] got=%b exp=%b", k, bus.cpu_hold, exp_d); end
      total++; if (bus.mem_addr !== (exp_d ? 32'h0000_0300 : 32'h0000_0200)) begin bad++; $display("FAIL starve_addr[%0d] got=%h", k, bus.mem_addr); end
      @(posedge clk); #1;
    end
`else
    exp_d = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      total++; if (bus.dma_gnt !== exp_d) begin bad++; $display("FAIL strict_dma_gnt[%0d] got=%b exp=0", k, bus.dma_gnt); end
      total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL strict_hold[%0d] got=%b exp=0", k, bus.cpu_hold); end
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL strict_release_gnt got=%b exp=1", bus.dma_gnt); end
    total++; if (bus.mem_addr !== 32'h0000_0300) begin bad++; $display("FAIL strict_release_addr got=%h exp=00000300", bus.mem_addr); end
    @(posedge clk); #1;
`endif
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_random_traffic();
    int          refused = 0;
    bit          pend = 0, pown = 0, c_held = 0, d_wait = 0;
    bit          e_force, e_cg, e_dg, e_en, e_we, e_rv, e_busy;
    logic [3:0]  e_wen;
    logic [31:0] pdata = 0, cq = 0, dq = 0, e_addr, e_din, e_cd, e_dd;
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!c_held) begin
        bus.cpu_req  = ($urandom_range(0, 99) < 60);
        bus.cpu_we   = 1'($urandom_range(0, 1));
        bus.cpu_wen  = 4'($urandom_range(1, 15));
        bus.cpu_addr = 32'($urandom_range(0, 63)) << 2;
        bus.cpu_din  = $urandom;
      end
      if (!d_wait) begin
        bus.dma_req  = ($urandom_range(0, 99) < 50);
        bus.dma_we   = 1'($urandom_range(0, 1));
        bus.dma_wen  = 4'($urandom_range(1, 15));
        bus.dma_addr = 32'($urandom_range(0, 63)) << 2;
        bus.dma_din  = $urandom;
      end
`ifdef DMEM_ARB_FAIRNESS_EN
      e_force = bus.dma_req && (refused == WMAX);
`else
      e_force = 1'b0;
`endif
      e_cg   = bus.cpu_req && !e_force;
      e_dg   = e_force || (!bus.cpu_req && bus.dma_req);
      e_en   = e_cg || e_dg;
      e_we   = e_cg ? bus.cpu_we : (e_dg ? bus.dma_we : 1'b0);
      e_wen  = !e_we ? 4'h0 : (e_cg ? bus.cpu_wen : bus.dma_wen);
      e_addr = e_cg ? bus.cpu_addr : (e_dg ? bus.dma_addr : 32'h0);
      e_din  = e_cg ? bus.cpu_din : (e_dg ? bus.dma_din : 32'h0);
      e_cd   = (pend && !pown) ? pdata : cq;
      e_rv   = pend && pown;
      e_dd   = e_rv ? pdata : dq;
      e_busy = pend || bus.cpu_req || bus.dma_req;
      @(negedge clk);
      total++; if (bus.mem_en !== e_en) begin bad++; $display("FAIL rnd_mem_en[%0d] got=%b exp=%b", cyc, bus.mem_en, e_en); end
      total++; if (bus.mem_wen !== e_wen) begin bad++; $display("FAIL rnd_mem_wen[%0d] got=%h exp=%h", cyc, bus.mem_wen, e_wen); end
      total++; if (bus.mem_addr !== e_addr) begin bad++; $display("FAIL rnd_mem_addr[%0d] got=%h exp=%h", cyc, bus.mem_addr, e_addr); end
      total++; if (bus.mem_din !== e_din) begin bad++; $display("FAIL rnd_mem_din[%0d] got=%h exp=%h", cyc, bus.mem_din, e_din); end
      total++; if (bus.cpu_hold !== (bus.cpu_req && !e_cg)) begin bad++; $display("FAIL rnd_hold[%0d] got=%b exp=%b", cyc, bus.cpu_hold, bus.cpu_req && !e_cg); end
      total++; if (bus.dma_gnt !== e_dg) begin bad++; $display("FAIL rnd_dma_gnt[%0d] got=%b exp=%b", cyc, bus.dma_gnt, e_dg); end
      total++; if (bus.dma_rvalid !== e_rv) begin bad++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", cyc, bus.dma_rvalid, e_rv); end
      total++; if (bus.cpu_dout !== e_cd) begin bad++; $display("FAIL rnd_cpu_dout[%0d] got=%h exp=%h", cyc, bus.cpu_dout, e_cd); end
      total++; if (bus.dma_dout !== e_dd) begin bad++; $display("FAIL rnd_dma_dout[%0d] got=%h exp=%h", cyc, bus.dma_dout, e_dd); end
      total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", cyc, bus.busy, e_busy); end
      if (pend && !pown) cq = pdata;
      if (e_rv) dq = pdata;
      pend  = e_en && !e_we;
      pown  = e_dg;
      if (pend) pdata = mem_rd(e_addr);
      refused = (bus.dma_req && !e_dg) ? ((refused < WMAX) ? refused + 1 : WMAX) : 0;
      c_held  = bus.cpu_req && !e_cg;
      d_wait  = bus.dma_req && !e_dg;
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h0000_0080;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rstrd_dma_gnt got=%b exp=1", bus.dma_gnt); end
    @(posedge clk); #1;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rstrd_rvalid_in_reset got=%b exp=0", bus.dma_rvalid); end
    total++; if (bus.dma_dout !== 32'h0) begin bad++; $display("FAIL rstrd_dout_in_reset got=%h exp=0", bus.dma_dout); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rstrd_rvalid[%0d] got=%b exp=0", k, bus.dma_rvalid); end
      total++; if (bus.dma_dout !== 32'h0) begin bad++; $display("FAIL rstrd_dma_dout[%0d] got=%h exp=0", k, bus.dma_dout); end
      total++; if (bus.cpu_dout !== 32'h0) begin bad++; $display("FAIL rstrd_cpu_dout[%0d] got=%h exp=0", k, bus.cpu_dout); end
      total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rstrd_mem_en[%0d] got=%b exp=0", k, bus.mem_en); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstrd_busy[%0d] got=%b exp=0", k, bus.busy); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_cpu_read();
    test_collision();
    test_starvation();
    test_random_traffic();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
